// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse generator with per-channel double-buffered period/high-time.
// Optional burst mode (fixed number of periods per load) is enabled with `define PULSE_GEN_BURST_EN.
module pulse_gen_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 25,
  parameter int PERIOD_DEF = 1000,
  parameter int HIGH_DEF   = 500,
`ifdef PULSE_GEN_BURST_EN
  parameter int BURST_W    = 8,
`endif
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
`ifdef PULSE_GEN_BURST_EN
  input  logic [BURST_W-1:0] cfg_burst,
  output logic [NUM_CH-1:0]  burst_done,
`endif
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] period_tick
);

  localparam logic [CNT_W-1:0] P_DEF = CNT_W'(PERIOD_DEF);
  localparam logic [CNT_W-1:0] H_DEF = CNT_W'(HIGH_DEF);
  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(2);

  logic              in_range;
  logic              wr_acc;
  logic [CNT_W-1:0]  wr_period;
  logic [NUM_CH-1:0] pend_full;

  // Out-of-range channel writes are always accepted and simply hit no channel.
  assign in_range  = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
  assign cfg_ready = in_range ? !pend_full[cfg_ch] : 1'b1;
  assign wr_acc    = cfg_valid && cfg_ready && in_range;
  assign wr_period = (cfg_period < P_MIN) ? P_MIN : cfg_period;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d, act_p_q, act_p_d, act_h_q, act_h_d;
      logic [CNT_W-1:0] pend_p_q, pend_p_d, pend_h_q, pend_h_d;
      logic             pend_v_q, pend_v_d, pulse_q, pulse_d, tick_q, tick_d;
      logic             wrap, wr_hit, stopped, load;
`ifdef PULSE_GEN_BURST_EN
      logic [BURST_W-1:0] act_b_q, act_b_d, pend_b_q, pend_b_d, bcnt_q, bcnt_d;
      logic               done_q, done_d;
      assign stopped = done_q;
`else
      assign stopped = 1'b0;
`endif

      assign wrap   = (cnt_q == act_p_q - CNT_W'(1));
      assign wr_hit = wr_acc && (cfg_ch == CH_W'(gi));

      always_comb begin
        cnt_d    = cnt_q;
        act_p_d  = act_p_q;
        act_h_d  = act_h_q;
        pend_p_d = pend_p_q;
        pend_h_d = pend_h_q;
        pend_v_d = pend_v_q;
        pulse_d  = 1'b0;
        tick_d   = 1'b0;
        load     = 1'b0;
`ifdef PULSE_GEN_BURST_EN
        act_b_d  = act_b_q;
        pend_b_d = pend_b_q;
        bcnt_d   = bcnt_q;
        done_d   = done_q;
`endif
        if (!ch_en[gi]) begin
          cnt_d  = '0;
`ifdef PULSE_GEN_BURST_EN
          bcnt_d = '0;
          done_d = 1'b0;
`endif
        end else if (!stopped) begin
          pulse_d = (cnt_q < act_h_q);
          tick_d  = wrap;
          cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
`ifdef PULSE_GEN_BURST_EN
          if (wrap && (act_b_q != '0)) begin
            if (bcnt_q == act_b_q - BURST_W'(1)) begin
              done_d = 1'b1;
              bcnt_d = '0;
            end else begin
              bcnt_d = bcnt_q + BURST_W'(1);
            end
          end
`endif
        end
        // Pending values only take effect at a period boundary or while idle, so no runt pulses.
        load = pend_v_q && (!ch_en[gi] || stopped || wrap);
        if (load) begin
          act_p_d  = pend_p_q;
          act_h_d  = pend_h_q;
          pend_v_d = 1'b0;
`ifdef PULSE_GEN_BURST_EN
          act_b_d  = pend_b_q;
          bcnt_d   = '0;
          done_d   = 1'b0;
`endif
        end
        if (wr_hit) begin
          pend_p_d = wr_period;
          pend_h_d = cfg_high;
          pend_v_d = 1'b1;
`ifdef PULSE_GEN_BURST_EN
          pend_b_d = cfg_burst;
`endif
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q    <= '0;
          act_p_q  <= P_DEF;
          act_h_q  <= H_DEF;
          pend_p_q <= '0;
          pend_h_q <= '0;
          pend_v_q <= 1'b0;
          pulse_q  <= 1'b0;
          tick_q   <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
          act_b_q  <= '0;
          pend_b_q <= '0;
          bcnt_q   <= '0;
          done_q   <= 1'b0;
`endif
        end else begin
          cnt_q    <= cnt_d;
          act_p_q  <= act_p_d;
          act_h_q  <= act_h_d;
          pend_p_q <= pend_p_d;
          pend_h_q <= pend_h_d;
          pend_v_q <= pend_v_d;
          pulse_q  <= pulse_d;
          tick_q   <= tick_d;
`ifdef PULSE_GEN_BURST_EN
          act_b_q  <= act_b_d;
          pend_b_q <= pend_b_d;
          bcnt_q   <= bcnt_d;
          done_q   <= done_d;
`endif
        end
      end

      assign pend_full[gi]   = pend_v_q;
      assign pulse_out[gi]   = pulse_q;
      assign period_tick[gi] = tick_q;
`ifdef PULSE_GEN_BURST_EN
      assign burst_done[gi]  = done_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Self-checking bench for pulse_gen_multi: per-cycle reference model feeding a scoreboard,
// plus directed checks of the documented scenarios (burst scenario when PULSE_GEN_BURST_EN is set).
module tb_pulse_gen_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 25;
  localparam int CH_W   = 2;
`ifdef PULSE_GEN_BURST_EN
  localparam int BURST_W = 8;
`endif

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_high;
  logic [NUM_CH-1:0] pulse_out;
  logic [NUM_CH-1:0] period_tick;
  logic [NUM_CH-1:0] done_obs;
`ifdef PULSE_GEN_BURST_EN
  logic [BURST_W-1:0] cfg_burst;
  logic [NUM_CH-1:0]  burst_done;
  assign done_obs = burst_done;
`else
  assign done_obs = '0;
`endif

  pulse_gen_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_DEF(1000), .HIGH_DEF(500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
`ifdef PULSE_GEN_BURST_EN
    .cfg_burst(cfg_burst), .burst_done(burst_done),
`endif
    .pulse_out(pulse_out), .period_tick(period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [NUM_CH-1:0] p;
    logic [NUM_CH-1:0] t;
    logic [NUM_CH-1:0] d;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state, one entry per channel.
  int m_cnt[NUM_CH], m_p[NUM_CH], m_h[NUM_CH], m_pp[NUM_CH], m_ph[NUM_CH];
  int m_ab[NUM_CH], m_pb[NUM_CH], m_bc[NUM_CH];
  bit m_pv[NUM_CH], m_pulse[NUM_CH], m_tick[NUM_CH], m_done[NUM_CH];

  task automatic model_cycle();
    bit rdy, acc, run, copy;
    int bval;
    exp_t e;
    rdy = (int'(cfg_ch) >= NUM_CH) ? 1'b1 : !m_pv[cfg_ch];
    acc = cfg_valid && rdy;
    bval = 0;
`ifdef PULSE_GEN_BURST_EN
    bval = int'(cfg_burst);
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0; m_pulse[i] = 0; m_tick[i] = 0; m_p[i] = 1000; m_h[i] = 500;
        m_pv[i] = 0; m_ab[i] = 0; m_bc[i] = 0; m_done[i] = 0;
      end else begin
        run  = ch_en[i] && !m_done[i];
        copy = 0;
        if (!run) begin
          m_pulse[i] = 0; m_tick[i] = 0; m_cnt[i] = 0;
          if (!ch_en[i]) begin m_bc[i] = 0; m_done[i] = 0; end
          copy = m_pv[i];
        end else begin
          m_pulse[i] = (m_cnt[i] < m_h[i]);
          m_tick[i]  = (m_cnt[i] == m_p[i] - 1);
          if (m_tick[i]) begin
            m_cnt[i] = 0;
            copy = m_pv[i];
            if (m_ab[i] != 0) begin
              m_bc[i]++;
              if (m_bc[i] == m_ab[i]) begin m_done[i] = 1; m_bc[i] = 0; end
            end
          end else begin
            m_cnt[i]++;
          end
        end
        if (copy) begin
          m_p[i] = m_pp[i]; m_h[i] = m_ph[i]; m_pv[i] = 0;
          m_ab[i] = m_pb[i]; m_bc[i] = 0; m_done[i] = 0;
        end
        if (acc && int'(cfg_ch) == i) begin
          m_pp[i] = (cfg_period < 2) ? 2 : int'(cfg_period);
          m_ph[i] = int'(cfg_high);
          m_pb[i] = bval;
          m_pv[i] = 1;
        end
      end
      e.p[i] = m_pulse[i];
      e.t[i] = m_tick[i];
      e.d[i] = m_done[i];
    end
    sb_q.push_back(e);
  endtask

  // One clock: check cfg_ready, push model expectation, clock, pop and compare outputs.
  task automatic step();
    exp_t e;
    #1;
    if (rst_n)
      chk("cfg_ready", cfg_ready, ((int'(cfg_ch) >= NUM_CH) ? 1'b1 : !m_pv[cfg_ch]));
    model_cycle();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("pulse_out", pulse_out, e.p);
    chk("period_tick", period_tick, e.t);
`ifdef PULSE_GEN_BURST_EN
    chk("burst_done", done_obs, e.d);
`endif
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cfg_write(input int ch, input int p, input int h, input int b);
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
`ifdef PULSE_GEN_BURST_EN
    cfg_burst  = BURST_W'(b);
`endif
    step();
    cfg_valid = 1'b0;
    $display("cfg write ch=%0d P=%0d H=%0d burst=%0d", ch, p, h, b);
  endtask

  int hi, tk, rises;
  logic prev;
  logic [9:0] pat;

  initial begin
    rst_n = 1'b0; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
`ifdef PULSE_GEN_BURST_EN
    cfg_burst = '0;
`endif
    @(posedge clk); #1;
    run(3);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_pulse", pulse_out, 0);
    chk("rst_tick", period_tick, 0);
    rst_n = 1'b1;
    step();

    // Defaults on channel 0: 500 high / 500 low, a tick every 1000 cycles.
    ch_en[0] = 1'b1;
    hi = 0; tk = 0;
    for (int k = 0; k < 2000; k++) begin
      step();
      hi += int'(pulse_out[0]);
      tk += int'(period_tick[0]);
    end
    chk("ch0_high_cycles", hi, 1000);
    chk("ch0_ticks", tk, 2);
    $display("ch0 defaults: high=%0d ticks=%0d", hi, tk);

    // Reconfigure channel 1 mid-period; new values apply only after the wrap.
    ch_en[1] = 1'b1;
    run(200);
    cfg_write(1, 10, 3, 0);
    cfg_ch = 2'd1; #1;
    chk("rdy_ch1_full", cfg_ready, 0);
    cfg_ch = 2'd2; #1;
    chk("rdy_ch2_free", cfg_ready, 1);
    cfg_ch = 2'd1;
    for (int k = 0; k < 1100 && !period_tick[1]; k++) step();
    chk("ch1_wrap_seen", period_tick[1], 1);
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      pat = {pat[8:0], pulse_out[1]};
    end
    chk("ch1_pattern", pat, 10'b1110000000);
    #1;
    chk("rdy_ch1_after_wrap", cfg_ready, 1);
    $display("ch1 new pattern %b", pat);

    // Degenerate periods clamp to 2: H=0 is constant low, H=5 is constant high.
    cfg_write(2, 0, 0, 0);
    step();
    ch_en[2] = 1'b1;
    hi = 0;
    for (int k = 0; k < 6; k++) begin step(); hi += int'(pulse_out[2]); end
    chk("ch2_const_low", hi, 0);
    cfg_write(2, 1, 5, 0);
    run(4);
    hi = 0;
    for (int k = 0; k < 6; k++) begin step(); hi += int'(pulse_out[2]); end
    chk("ch2_const_high", hi, 6);
    $display("ch2 clamp checks done");

    // Drop enable mid-high, then re-enable: full high phase starts one cycle later.
    for (int k = 0; k < 12 && !pulse_out[1]; k++) step();
    chk("ch1_high_seen", pulse_out[1], 1);
    ch_en[1] = 1'b0;
    step();
    chk("ch1_drop_low", pulse_out[1], 0);
    ch_en[1] = 1'b1;
    step();
    chk("ch1_reen_high", pulse_out[1], 1);
    hi = 1;
    for (int k = 0; k < 9; k++) begin step(); hi += int'(pulse_out[1]); end
    chk("ch1_reen_highs", hi, 3);
    $display("ch1 enable drop/restore done");

    // Reset discards a pending write; defaults resume.
    ch_en[3] = 1'b1;
    run(5);
    cfg_write(3, 10, 3, 0);
    cfg_ch = 2'd3; #1;
    chk("rdy_ch3_pending", cfg_ready, 0);
    ch_en[3] = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rdy_ch3_after_rst", cfg_ready, 1);
    run(2);
    ch_en[3] = 1'b1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin step(); hi += int'(pulse_out[3]); end
    chk("ch3_defaults_after_rst", hi, 20);
    $display("reset discard check done");

`ifdef PULSE_GEN_BURST_EN
    // Burst of 3 periods with P=4, H=2, then stopped with burst_done.
    ch_en[0] = 1'b0;
    cfg_write(0, 4, 2, 3);
    step();
    ch_en[0] = 1'b1;
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (pulse_out[0] && !prev) rises++;
      prev = pulse_out[0];
    end
    chk("burst_pulses", rises, 3);
    chk("burst_done_set", burst_done[0], 1);
    chk("burst_out_low", pulse_out[0], 0);
    $display("burst: pulses=%0d done=%0b", rises, burst_done[0]);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_gen_multi.md
PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent pulse channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 25, meaning the width of the period, high-time and channel counters.
REQ-003 SHALL have parameter PERIOD_DEF, default 1000, meaning the active period in cycles after reset.
REQ-004 SHALL have parameter HIGH_DEF, default 500, meaning the active high-time in cycles after reset.
REQ-005 SHALL have port clk  input  1  meaning the single system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-007 SHALL have port ch_en  input  NUM_CH  meaning per-channel run enable.
REQ-008 SHALL have port cfg_valid  input  1  meaning a configuration write is offered.
REQ-009 SHALL have port cfg_ready  output  1  meaning a configuration write can be accepted this cycle.
REQ-010 SHALL have port cfg_ch  input  clog2(NUM_CH), minimum 1  meaning the target channel index.
REQ-011 SHALL have port cfg_period  input  CNT_W  meaning the new period in cycles.
REQ-012 SHALL have port cfg_high  input  CNT_W  meaning the new high-time in cycles.
REQ-013 SHALL have port pulse_out  output  NUM_CH  meaning registered pulse outputs.
REQ-014 SHALL have port period_tick  output  NUM_CH  meaning a one-cycle strobe on each period wrap.

Function
REQ-015 A write SHALL be accepted on a cycle with cfg_valid=1 and cfg_ready=1; it stores {period, high} in the target channel's single pending slot.
REQ-016 cfg_ready SHALL be 0 only while the pending slot of the channel addressed by cfg_ch is full; it is combinational on cfg_ch.
REQ-017 A write with cfg_ch >= NUM_CH SHALL be accepted and discarded.
REQ-018 A stored period below 2 SHALL be clamped to 2; the high-time is stored unmodified.
REQ-019 While ch_en[i]=1 with count c: next c = (c == P-1) ? 0 : c+1, where P is the active period and H the active high-time.
REQ-020 pulse_out[i] SHALL be registered from that same cycle as (c < H); H=0 gives constant low and H>=P gives constant high.
REQ-021 period_tick[i] SHALL be 1 for exactly the cycle after the cycle where c == P-1.
REQ-022 If the pending slot is full on a cycle where c == P-1, it SHALL be copied into the active P/H and emptied, so the new values apply from c=0 and no runt pulse is produced.
REQ-023 While ch_en[i]=0: the count SHALL be held at 0, and pulse_out[i] and period_tick[i] SHALL be 0 on the next cycle.
REQ-024 While ch_en[i]=0, any pending value SHALL be copied to active on the same cycle it is present.
REQ-025 Latency SHALL be one cycle: the first cycle with ch_en=1 evaluates c=0, so pulse_out rises on the following cycle when H>0.
REQ-026 If a write is accepted on the same cycle the slot empties, the slot SHALL be refilled with the new write (copy first, then store).
REQ-027 Channels SHALL be fully independent; a write affects only its target channel.

Reset
REQ-028 While rst_n=0 at a clk edge: all counts=0, pulse_out=0, period_tick=0, active P=PERIOD_DEF, active H=HIGH_DEF, pending slots empty, so cfg_ready=1.
REQ-029 Reset SHALL override any in-progress period or pending write; the first post-reset cycle behaves as REQ-025.

Configuration
REQ-030 Macro PULSE_GEN_BURST_EN, when defined, SHALL add parameter BURST_W (default 8), input cfg_burst[BURST_W] stored with each write, and output burst_done[NUM_CH].
REQ-031 With PULSE_GEN_BURST_EN defined, burst count 0 SHALL mean continuous operation.
REQ-032 With PULSE_GEN_BURST_EN defined and burst count N>0, the channel SHALL emit N full periods after enable or after load, then hold count 0 with pulse_out=0.
REQ-033 In that stopped state burst_done SHALL be 1 until ch_en falls or a new value is loaded.
REQ-034 Without PULSE_GEN_BURST_EN, those ports and logic SHALL be absent and the behaviour SHALL be continuous only.

Verification
REQ-035 Reset, then ch_en[0]=1 with defaults -> pulse_out[0] is high 500 cycles and low 500 cycles, and period_tick[0] pulses every 1000 cycles.
REQ-036 Write ch1 P=10, H=3 mid-period -> the current period completes unchanged, then the output is 3 high and 7 low; cfg_ready is 0 for ch1 until the wrap and stays 1 for ch2.
REQ-037 Write P=0, H=0 and then P=1, H=5 -> these are clamped to P=2; the output is constant 0, then constant 1.
REQ-038 Drop ch_en mid-high -> pulse_out is 0 the next cycle; re-enable -> a full high phase starts one cycle later.
REQ-039 Assert rst_n=0 while a write is pending -> the pending write is lost and defaults resume.
REQ-040 With PULSE_GEN_BURST_EN defined, P=4, H=2, burst=3 -> exactly 3 pulses occur, then burst_done=1 and pulse_out stays 0.
